// File: rtl/cpu_core_pkg.sv
// Shared definitions for the cpu_core accumulator CPU: default widths, opcodes, FSM states.
package cpu_core_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 16;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDAC = 4'h1;
    localparam logic [3:0] OP_STAC = 4'h2;
    localparam logic [3:0] OP_MVAC = 4'h3;
    localparam logic [3:0] OP_MOVR = 4'h4;
    localparam logic [3:0] OP_JUMP = 4'h5;
    localparam logic [3:0] OP_JMPZ = 4'h6;
    localparam logic [3:0] OP_JPNZ = 4'h7;
    localparam logic [3:0] OP_ADD  = 4'h8;
    localparam logic [3:0] OP_SUB  = 4'h9;
    localparam logic [3:0] OP_INAC = 4'hA;
    localparam logic [3:0] OP_CLAC = 4'hB;
    localparam logic [3:0] OP_AND  = 4'hC;
    localparam logic [3:0] OP_OR   = 4'hD;
    localparam logic [3:0] OP_XOR  = 4'hE;
    localparam logic [3:0] OP_NOT  = 4'hF;

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        FET1 = 4'd1,
        FET2 = 4'd2,
        DEC  = 4'd3,
        ADR1 = 4'd4,
        ADR2 = 4'd5,
        MEM  = 4'd6
    } state_e;

    // Opcodes followed by a two-word address operand.
    function automatic logic is_addr_op(input logic [3:0] op);
        logic res;
        case (op)
            OP_LDAC, OP_STAC, OP_JUMP, OP_JMPZ, OP_JPNZ: res = 1'b1;
            default:                                     res = 1'b0;
        endcase
        return res;
    endfunction

    function automatic logic is_mem_op(input logic [3:0] op);
        logic res;
        case (op)
            OP_LDAC, OP_STAC: res = 1'b1;
            default:          res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/cpu_core_alu.sv
// Combinational ALU for opcodes 8-F; result is modulo 2^DATA_W, zero flags a zero result.
module cpu_core_alu
    import cpu_core_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [3:0]        op_i,
    input  logic [DATA_W-1:0] ac_i,
    input  logic [DATA_W-1:0] r_i,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o
);

    // Result selection and zero detect
    always_comb begin
        result_o = ac_i;
        case (op_i)
            OP_ADD:  result_o = ac_i + r_i;
            OP_SUB:  result_o = ac_i - r_i;
            OP_INAC: result_o = ac_i + DATA_W'(1'b1);
            OP_CLAC: result_o = {DATA_W{1'b0}};
            OP_AND:  result_o = ac_i & r_i;
            OP_OR:   result_o = ac_i | r_i;
            OP_XOR:  result_o = ac_i ^ r_i;
            OP_NOT:  result_o = ~ac_i;
            default: result_o = ac_i;
        endcase
        zero_o = (result_o == {DATA_W{1'b0}});
    end

endmodule

// File: rtl/cpu_core.sv
// Multi-cycle accumulator CPU core with wait-state memory handshake and run/stop control.
// Optional single-step inputs (step_mode, step) are enabled by defining CPU_CORE_STEP_EN.
module cpu_core
    import cpu_core_pkg::*;
#(
    parameter int                DATA_W   = DATA_W_DEF,
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
`ifdef CPU_CORE_STEP_EN
    input  logic              step_mode,
    input  logic              step,
`endif
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] ac_o,
    output logic [DATA_W-1:0] r_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              z_o,
    output logic [3:0]        state_o
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, ar_q, ar_d;
    logic [3:0]        ir_q, ir_d;
    logic [DATA_W-1:0] tr_q, tr_d, ac_q, ac_d, r_q, r_d, wdata_q, wdata_d;
    logic              z_q, z_d, rd_q, rd_d, wr_q, wr_d;

    logic [DATA_W-1:0] alu_res_s;
    logic              alu_zero_s;
    logic [ADDR_W-1:0] target_s;
    logic              go_s, cont_s, taken_s;

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1'b1);

    // go_s starts an instruction from IDLE; cont_s chains into the next one at instruction end.
`ifdef CPU_CORE_STEP_EN
    assign go_s   = step_mode ? step : run;
    assign cont_s = step_mode ? 1'b0 : run;
`else
    assign go_s   = run;
    assign cont_s = run;
`endif

    assign target_s = ADDR_W'({mem_rdata, tr_q});
    assign taken_s  = (ir_q == OP_JUMP) || ((ir_q == OP_JMPZ) && z_q) || ((ir_q == OP_JPNZ) && !z_q);

    cpu_core_alu #(.DATA_W(DATA_W)) u_alu (
        .op_i     (ir_q),
        .ac_i     (ac_q),
        .r_i      (r_q),
        .result_o (alu_res_s),
        .zero_o   (alu_zero_s)
    );

    // Next-state and datapath update logic
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ar_d    = ar_q;
        ir_d    = ir_q;
        tr_d    = tr_q;
        ac_d    = ac_q;
        r_d     = r_q;
        z_d     = z_q;
        case (state_q)
            IDLE: begin
                if (go_s) state_d = FET1;
                else      state_d = IDLE;
            end
            FET1: begin
                ar_d    = pc_q;
                state_d = FET2;
            end
            FET2: begin
                if (mem_ready) begin
                    ir_d    = mem_rdata[3:0];
                    pc_d    = pc_q + ADDR_ONE;
                    state_d = DEC;
                end else begin
                    state_d = FET2;
                end
            end
            DEC: begin
                if (is_addr_op(ir_q)) begin
                    ar_d    = pc_q;
                    state_d = ADR1;
                end else begin
                    if (ir_q == OP_MVAC) begin
                        r_d = ac_q;
                    end else if (ir_q == OP_MOVR) begin
                        ac_d = r_q;
                    end else if (ir_q[3]) begin
                        ac_d = alu_res_s;
                        z_d  = alu_zero_s;
                    end else begin
                        ac_d = ac_q;
                    end
                    state_d = cont_s ? FET1 : IDLE;
                end
            end
            ADR1: begin
                if (mem_ready) begin
                    tr_d    = mem_rdata;
                    pc_d    = pc_q + ADDR_ONE;
                    ar_d    = ar_q + ADDR_ONE;
                    state_d = ADR2;
                end else begin
                    state_d = ADR1;
                end
            end
            ADR2: begin
                if (mem_ready) begin
                    pc_d = pc_q + ADDR_ONE;
                    if (is_mem_op(ir_q)) begin
                        ar_d    = target_s;
                        state_d = MEM;
                    end else begin
                        if (taken_s) pc_d = target_s;
                        else         pc_d = pc_q + ADDR_ONE;
                        state_d = cont_s ? FET1 : IDLE;
                    end
                end else begin
                    state_d = ADR2;
                end
            end
            MEM: begin
                if (mem_ready) begin
                    if (ir_q == OP_LDAC) ac_d = mem_rdata;
                    else                 ac_d = ac_q;
                    state_d = cont_s ? FET1 : IDLE;
                end else begin
                    state_d = MEM;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus requests are derived from the upcoming state so they leave the core registered.
    always_comb begin
        rd_d = (state_d == FET2) || (state_d == ADR1) || (state_d == ADR2) ||
               ((state_d == MEM) && (ir_q == OP_LDAC));
        wr_d = (state_d == MEM) && (ir_q == OP_STAC);
        if (wr_d) wdata_d = ac_q;
        else      wdata_d = wdata_q;
    end

    // State and register file
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            ar_q    <= {ADDR_W{1'b0}};
            ir_q    <= 4'h0;
            tr_q    <= {DATA_W{1'b0}};
            ac_q    <= {DATA_W{1'b0}};
            r_q     <= {DATA_W{1'b0}};
            z_q     <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            wdata_q <= {DATA_W{1'b0}};
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ar_q    <= ar_d;
            ir_q    <= ir_d;
            tr_q    <= tr_d;
            ac_q    <= ac_d;
            r_q     <= r_d;
            z_q     <= z_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
        end
    end

    assign mem_addr  = ar_q;
    assign mem_rd    = rd_q;
    assign mem_wr    = wr_q;
    assign mem_wdata = wdata_q;
    assign ac_o      = ac_q;
    assign r_o       = r_q;
    assign pc_o      = pc_q;
    assign z_o       = z_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_cpu_core.sv
// Scoreboard bench for cpu_core: an instruction-level reference model predicts bus accesses
// and end-of-instruction architectural state; a monitor compares them as the core runs.
`timescale 1ns/1ps
module tb_cpu_core;
    import cpu_core_pkg::*;

    logic        clk = 1'b0;
    logic        rst, run;
    logic [15:0] mem_addr;
    logic        mem_rd, mem_wr, mem_ready;
    logic [7:0]  mem_wdata, mem_rdata, ac_o, r_o;
    logic [15:0] pc_o;
    logic        z_o;
    logic [3:0]  state_o;
`ifdef CPU_CORE_STEP_EN
    logic        step_mode = 1'b0;
    logic        step = 1'b0;
`endif

    cpu_core #(.DATA_W(8), .ADDR_W(16), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst), .run(run),
`ifdef CPU_CORE_STEP_EN
        .step_mode(step_mode), .step(step),
`endif
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .ac_o(ac_o), .r_o(r_o), .pc_o(pc_o), .z_o(z_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory: DUT-side array and an independent copy owned by the reference model.
    logic [7:0] mem [0:65535];
    logic [7:0] mm  [0:65535];
    assign mem_rdata = mem[mem_addr];

    typedef struct packed { logic wr; logic [15:0] addr; logic [7:0] data; } acc_t;
    typedef struct packed { logic [7:0] ac; logic [7:0] r; logic z; logic [15:0] pc; int cyc; } arch_t;
    acc_t  exp_acc[$];
    arch_t exp_arch[$];
    int    cyc_log[$];
    logic [15:0] rd_log[$];
    int    n_started, n_done, wr_count;

    // Wait-state responder
    int   fixed_wait = 0, max_wait = 0, wcnt = 0, wtarget = 0;
    logic no_fetch_wait = 1'b0;
    logic last_done = 1'b0;
    function automatic int pick_wait();
        return (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(max_wait, 0));
    endfunction
    initial begin
        mem_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (last_done) begin wcnt = 0; wtarget = pick_wait(); end
            if ((mem_rd || mem_wr) && wcnt < wtarget && !(no_fetch_wait && state_o == FET2)) begin
                mem_ready = 1'b0;
                wcnt++;
            end else begin
                mem_ready = 1'b1;
            end
            last_done = (mem_rd || mem_wr) && mem_ready;
        end
    end

    // Monitor: pops expected accesses and instruction results as the DUT presents them.
    initial begin
        logic [3:0] prev;
        int cnt, waits;
        acc_t  ea;
        arch_t es;
        prev = IDLE; cnt = 0; waits = 0;
        forever begin
            @(negedge clk); #1;
            if (rst) begin
                prev = IDLE; cnt = 0; waits = 0;
            end else begin
                if ((state_o == FET1 || state_o == IDLE) && (prev == DEC || prev == ADR2 || prev == MEM)) begin
                    if (exp_arch.size() == 0) begin
                        chk("arch_unexpected", 32'd1, 32'd0);
                    end else begin
                        es = exp_arch.pop_front();
                        chk("ac", ac_o, es.ac);
                        chk("r", r_o, es.r);
                        chk("z", z_o, es.z);
                        chk("pc", pc_o, es.pc);
                        chk("cycles", cnt, es.cyc + waits);
                    end
                    cyc_log.push_back(cnt);
                    n_done++;
                end
                if (state_o == FET1 && prev != FET1) begin cnt = 0; waits = 0; n_started++; end
                if (state_o != IDLE) cnt++;
                if ((mem_rd || mem_wr) && !mem_ready) waits++;
                if (mem_wr && exp_acc.size() > 0) chk("wdata", mem_wdata, exp_acc[0].data);
                if ((mem_rd || mem_wr) && mem_ready) begin
                    if (exp_acc.size() == 0) begin
                        chk("acc_unexpected", mem_addr, 32'hFFFFFFFF);
                    end else begin
                        ea = exp_acc.pop_front();
                        chk("rd_wr_excl", mem_rd && mem_wr, 32'd0);
                        chk("acc_kind", mem_wr, ea.wr);
                        chk("acc_addr", mem_addr, ea.addr);
                    end
                    if (mem_wr) begin mem[mem_addr] = mem_wdata; wr_count++; end
                    else        rd_log.push_back(mem_addr);
                end
                prev = state_o;
            end
        end
    end

    // Reference model: executes one instruction at ISA level.
    logic [7:0]  m_ac, m_r;
    logic        m_z;
    logic [15:0] m_pc;
    task automatic model_step();
        logic [3:0]  op;
        logic [15:0] a;
        logic [7:0]  res;
        int          base;
        op = mm[m_pc][3:0];
        exp_acc.push_back('{wr: 1'b0, addr: m_pc, data: 8'h00});
        m_pc = m_pc + 16'd1;
        base = 3;
        if (op == 4'h1 || op == 4'h2 || op == 4'h5 || op == 4'h6 || op == 4'h7) begin
            exp_acc.push_back('{wr: 1'b0, addr: m_pc, data: 8'h00});
            a[7:0] = mm[m_pc];
            m_pc = m_pc + 16'd1;
            exp_acc.push_back('{wr: 1'b0, addr: m_pc, data: 8'h00});
            a[15:8] = mm[m_pc];
            m_pc = m_pc + 16'd1;
            base = 5;
            if (op == 4'h1) begin
                exp_acc.push_back('{wr: 1'b0, addr: a, data: 8'h00});
                m_ac = mm[a]; base = 6;
            end else if (op == 4'h2) begin
                exp_acc.push_back('{wr: 1'b1, addr: a, data: m_ac});
                mm[a] = m_ac; base = 6;
            end else if (op == 4'h5 || (op == 4'h6 && m_z) || (op == 4'h7 && !m_z)) begin
                m_pc = a;
            end
        end else if (op == 4'h3) begin
            m_r = m_ac;
        end else if (op == 4'h4) begin
            m_ac = m_r;
        end else if (op >= 4'h8) begin
            case (op)
                4'h8: res = m_ac + m_r;
                4'h9: res = m_ac - m_r;
                4'hA: res = m_ac + 8'd1;
                4'hB: res = 8'h00;
                4'hC: res = m_ac & m_r;
                4'hD: res = m_ac | m_r;
                4'hE: res = m_ac ^ m_r;
                default: res = ~m_ac;
            endcase
            m_ac = res;
            m_z  = (res == 8'h00);
        end
        exp_arch.push_back('{ac: m_ac, r: m_r, z: m_z, pc: m_pc, cyc: base});
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0;
        repeat (2) @(negedge clk);
        exp_acc.delete(); exp_arch.delete(); cyc_log.delete(); rd_log.delete();
        n_started = 0; n_done = 0; wr_count = 0;
        wcnt = 0; wtarget = pick_wait(); last_done = 1'b0;
        m_ac = 8'h00; m_r = 8'h00; m_z = 1'b0; m_pc = 16'h0000;
        for (int i = 0; i < 65536; i++) mm[i] = mem[i];
        rst = 1'b0;
    endtask

    task automatic run_instr(input int k);
        int budget;
        for (int i = 0; i < k; i++) model_step();
        budget = 0;
        run = 1'b1;
        while (n_started < k && budget < 20000) begin @(negedge clk); budget++; end
        run = 1'b0;
        while (!(n_done >= k && state_o == IDLE) && budget < 20000) begin @(negedge clk); budget++; end
        #2;
        if (budget >= 20000) chk("run_timeout", budget, 32'd0);
        chk("queues_drained", exp_acc.size() + exp_arch.size(), 32'd0);
    endtask

    initial begin
        rst = 1'b1; run = 1'b0;
        clear_mem();
        fixed_wait = 0;

        // Reset values
        do_reset(); #1;
        chk("rst_pc", pc_o, 16'h0000);
        chk("rst_ac", ac_o, 8'h00);
        chk("rst_r", r_o, 8'h00);
        chk("rst_z", z_o, 1'b0);
        chk("rst_rdwr", {mem_rd, mem_wr}, 2'b00);
        chk("rst_wdata", mem_wdata, 8'h00);
        chk("rst_addr", mem_addr, 16'h0000);
        chk("rst_state", state_o, IDLE);

        // INAC
        clear_mem(); mem[0] = 8'h0A;
        do_reset(); run_instr(1);
        chk("inac_ac", ac_o, 8'h01);
        chk("inac_z", z_o, 1'b0);
        chk("inac_pc", pc_o, 16'h0001);
        chk("inac_cyc", cyc_log[0], 3);

        // LDAC 0x1234, MVAC, ADD
        clear_mem();
        mem[0] = 8'h01; mem[1] = 8'h34; mem[2] = 8'h12; mem[3] = 8'h03; mem[4] = 8'h08;
        mem[16'h1234] = 8'h80;
        do_reset(); run_instr(3);
        chk("add_ac", ac_o, 8'h00);
        chk("add_z", z_o, 1'b1);
        chk("add_r", r_o, 8'h80);
        chk("ldac_cyc", cyc_log[0], 6);

        // Wait states on STAC 0x0010 with AC=0x5A
        clear_mem();
        mem[0] = 8'h01; mem[1] = 8'h00; mem[2] = 8'h01; mem[16'h0100] = 8'h5A;
        mem[3] = 8'h02; mem[4] = 8'h10; mem[5] = 8'h00;
        fixed_wait = 3; no_fetch_wait = 1'b1;
        do_reset(); run_instr(2);
        chk("stac_mem", mem[16'h0010], 8'h5A);
        chk("stac_writes", wr_count, 1);
        chk("stac_cyc", cyc_log[1], 15);
        fixed_wait = 0; no_fetch_wait = 1'b0;

        // JMPZ not taken, then taken
        clear_mem(); mem[0] = 8'h06; mem[1] = 8'h40; mem[2] = 8'h00;
        do_reset(); run_instr(1);
        chk("jmpz_nt_pc", pc_o, 16'h0003);
        clear_mem(); mem[0] = 8'h0B; mem[1] = 8'h06; mem[2] = 8'h40; mem[3] = 8'h00;
        do_reset(); run_instr(2);
        chk("jmpz_t_pc", pc_o, 16'h0040);
        chk("jmpz_t_cyc", cyc_log[1], 5);

        // Operand wrap past 0xFFFF
        clear_mem(); mem[0] = 8'h05; mem[1] = 8'hFF; mem[2] = 8'hFF; mem[16'hFFFF] = 8'h05;
        do_reset(); run_instr(2);
        chk("wrap_fetch", rd_log[3], 16'hFFFF);
        chk("wrap_lo", rd_log[4], 16'h0000);
        chk("wrap_hi", rd_log[5], 16'h0001);
        chk("wrap_pc", pc_o, 16'hFF05);

        // Reset during a pending LDAC data read
        clear_mem(); mem[0] = 8'h01; mem[1] = 8'h34; mem[2] = 8'h12; mem[16'h1234] = 8'h80;
        fixed_wait = 20;
        do_reset(); model_step();
        run = 1'b1;
        for (int i = 0; i < 200 && state_o != MEM; i++) @(negedge clk);
        @(negedge clk);
        chk("pend_state", state_o, MEM);
        chk("pend_rd", mem_rd, 1'b1);
        rst = 1'b1; run = 1'b0; #1;
        chk("arst_rd", mem_rd, 1'b0);
        chk("arst_state", state_o, IDLE);
        chk("arst_ac", ac_o, 8'h00);
        chk("arst_pc", pc_o, 16'h0000);
        chk("arst_addr", mem_addr, 16'h0000);
        fixed_wait = 0;

        // Randomized programs with random wait states
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
            fixed_wait = -1; max_wait = s;
            do_reset(); run_instr(40);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
